wgt_pingpong_buffer: RTL and testbench
======================================

Name: wgt_pingpong_buffer

Overview:
- Parametrised, double-banked (ping-pong) successor to the single-bank weight buffer. Sits between img2col_weight and the cube/MAC array.
- img2col_weight fills one bank while the array drains the other. Each entry stores a weight word plus its valid-lane count (num_valid).
- A bank is handed to the reader only after an explicit commit. The reader returns it with an explicit release.

Parameters:
- DATA_W, 128, width of one weight word (weights_in / rd_data).
- DEPTH, 128, entries per bank.
- NUM_W, 4, width of the valid-lane count stored per entry.
- ADDR_W, $clog2(DEPTH), localparam, address width (7 at defaults).

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- wgt_wr_en  in  1  write strobe from img2col_weight.
- wgt_wr_addr  in  ADDR_W  entry address within the current write bank.
- weights_in  in  DATA_W  weight word to store.
- valid_num  in  NUM_W  valid lanes in weights_in.
- wr_commit  in  1  pulse: current write bank is complete.
- rd_en  in  1  read strobe from consumer.
- rd_addr  in  ADDR_W  entry address within the current read bank.
- rd_release  in  1  pulse: consumer is finished with the read bank.
- rd_data  out  DATA_W  registered read word.
- rd_num  out  NUM_W  registered valid-lane count of the read word.
- rd_valid  out  1  rd_data/rd_num valid this cycle.
- rd_count  out  ADDR_W+1  entries in the current read bank (0 if not FULL).
- buf_empty  out  1  no bank is FULL.
- buf_full  out  1  both banks are FULL; writer must hold off.
- wr_overflow  out  1  sticky: a write or commit arrived while buf_full.

Behaviour:
- Reset (rst_n=0 at posedge): both banks EMPTY, wb=0, rb=0, both counts=0.
- Outputs after reset: rd_data=0, rd_num=0, rd_valid=0, rd_count=0, buf_empty=1, buf_full=0, wr_overflow=0.
- Memory contents are not cleared on reset. Reset mid-operation discards all banks.
- Per-bank state: EMPTY -> FILLING (first accepted write) -> FULL (wr_commit) -> EMPTY (rd_release while it is the read bank).
- Write: accepted when bank[wb] is EMPTY or FILLING.
  - Stores weights_in and valid_num at wgt_wr_addr.
  - hi[wb] tracks the highest written address + 1.
  - A rewrite to the same address overwrites the entry.
- Write while bank[wb] is FULL: write dropped, wr_overflow set. wr_overflow is cleared only by reset.
- wr_commit with bank[wb] FILLING: bank -> FULL, count[wb]=hi[wb], wb toggles, hi cleared.
- wr_commit with bank[wb] EMPTY: no effect.
- wr_commit while bank[wb] is FULL: dropped, wr_overflow set.
- A write and a commit in the same cycle: the write is included, and count includes it.
- Read, 1-cycle latency: rd_en at cycle N with bank[rb] FULL and rd_addr < count[rb] gives rd_valid=1, rd_data and rd_num at N+1.
  - Otherwise rd_valid=0 at N+1, and rd_data/rd_num hold their previous value.
- rd_release with bank[rb] FULL: bank -> EMPTY, count cleared, rb toggles.
- rd_release with bank[rb] not FULL: ignored.
- An rd_en in the same cycle as rd_release still reads the old bank.
- Commit and release in the same cycle both take effect. Releasing bank A while committing bank B leaves buf_full=0 and buf_empty=0.
- rd_count, buf_empty and buf_full are combinational from bank state, which is registered. They reflect the commit/release one cycle after the pulse.
- Address wrap: none. An address >= DEPTH cannot be expressed when DEPTH is a power of two. Otherwise, writes to an address >= DEPTH are dropped.
- Banks alternate strictly: the reader always consumes in commit order.

Decomposition:
- Shared package wgt_buf_pkg:
  - bank-state enum {BANK_EMPTY, BANK_FILLING, BANK_FULL};
  - default DATA_W/DEPTH/NUM_W constants, shared with img2col_weight.
- One sub-module, wgt_bank_ram: simple dual-port, 1 write / 1 registered read, width DATA_W+NUM_W, depth DEPTH. Instantiated twice.

Test Plan:
- Reset: rst_n low 5 cycles -> buf_empty=1, buf_full=0, rd_valid=0, rd_count=0, wr_overflow=0.
- Single fill/drain: write addr 0..26 with data=addr+1, valid_num=3, then commit -> next cycle buf_empty=0, rd_count=27. Read addr 5 -> next cycle rd_data=6, rd_num=3, rd_valid=1.
- Ping-pong: fill and commit bank0 (9 entries) and bank1 (9 entries) -> buf_full=1. A 19th write gets dropped and sets wr_overflow=1. Release -> rd_count=9 from bank1, buf_full=0.
- Simultaneous commit+release: bank0 FULL and bank1 FILLING; pulse wr_commit and rd_release together -> bank1 becomes read bank, buf_empty=0, buf_full=0.
- Out-of-range read: committed count=9, rd_en addr 9 -> rd_valid=0. Empty-bank commit and stray rd_release -> no state change.
- Mid-operation reset: rst_n low while bank0 FULL and bank1 FILLING -> both EMPTY, wb=rb=0, buf_empty=1.

Source files
------------

// File: rtl/wgt_pingpong_buffer_pkg.sv
// Shared definitions for the weight ping-pong buffer and its img2col_weight producer.
package wgt_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

  localparam int unsigned WGT_DATA_W = 128;
  localparam int unsigned WGT_DEPTH  = 128;
  localparam int unsigned WGT_NUM_W  = 4;

endpackage

// File: rtl/wgt_pingpong_buffer_if.sv
// Writer/reader bus of the weight ping-pong buffer; master = producer/consumer side.
interface wgt_pingpong_buffer_if
  import wgt_buf_pkg::*;
#(
  parameter int unsigned DATA_W = WGT_DATA_W,
  parameter int unsigned DEPTH  = WGT_DEPTH,
  parameter int unsigned NUM_W  = WGT_NUM_W
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wgt_wr_en;
  logic [ADDR_W-1:0] wgt_wr_addr;
  logic [DATA_W-1:0] weights_in;
  logic [NUM_W-1:0]  valid_num;
  logic              wr_commit;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_release;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_W-1:0]  rd_num;
  logic              rd_valid;
  logic [ADDR_W:0]   rd_count;
  logic              buf_empty;
  logic              buf_full;
  logic              wr_overflow;

  modport master (
    output wgt_wr_en, wgt_wr_addr, weights_in, valid_num, wr_commit,
    output rd_en, rd_addr, rd_release,
    input  rd_data, rd_num, rd_valid, rd_count, buf_empty, buf_full, wr_overflow
  );

  modport slave (
    input  wgt_wr_en, wgt_wr_addr, weights_in, valid_num, wr_commit,
    input  rd_en, rd_addr, rd_release,
    output rd_data, rd_num, rd_valid, rd_count, buf_empty, buf_full, wr_overflow
  );

endinterface

// File: rtl/wgt_pingpong_buffer_bank_ram.sv
// One weight bank: simple dual-port RAM, one write port and one registered read port.
module wgt_bank_ram #(
  parameter  int unsigned WIDTH  = 132,
  parameter  int unsigned DEPTH  = 128,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clock) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wgt_pingpong_buffer.sv
// Double-banked weight buffer: writer fills bank wb, reader drains committed bank rb.
module wgt_pingpong_buffer
  import wgt_buf_pkg::*;
#(
  parameter int unsigned DATA_W = WGT_DATA_W,
  parameter int unsigned DEPTH  = WGT_DEPTH,
  parameter int unsigned NUM_W  = WGT_NUM_W
) (
  input logic                  clock,
  input logic                  rst_n,
  wgt_pingpong_buffer_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned ENT_W  = DATA_W + NUM_W;

  bank_state_e      state   [2];
  bank_state_e      state_n [2];
  logic [CNT_W-1:0] count   [2];
  logic [CNT_W-1:0] count_n [2];
  logic [CNT_W-1:0] hi, hi_n, hi_wr, wr_addr_ext;
  logic             wb, wb_n, rb, rb_n, ovf, ovf_n;
  logic             wr_ok, rd_ok, sel, rd_valid_q;
  logic [ENT_W-1:0] q [2];

  assign wr_addr_ext = CNT_W'(bus.wgt_wr_addr);
  assign rd_ok = bus.rd_en && (state[rb] == BANK_FULL) && (CNT_W'(bus.rd_addr) < count[rb]);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= BANK_EMPTY;
        count[i] <= '0;
      end
      hi         <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      ovf        <= 1'b0;
      rd_valid_q <= 1'b0;
      sel        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= state_n[i];
        count[i] <= count_n[i];
      end
      hi         <= hi_n;
      wb         <= wb_n;
      rb         <= rb_n;
      ovf        <= ovf_n;
      rd_valid_q <= rd_ok;
      if (rd_ok) sel <= rb;
    end
  end

  // Write, commit and release all evaluate against current state; a commit sees the
  // same-cycle write through hi_wr and state_n, and release only touches bank rb.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_n[i] = state[i];
      count_n[i] = count[i];
    end
    wb_n  = wb;
    rb_n  = rb;
    ovf_n = ovf;
    wr_ok = 1'b0;
    hi_wr = hi;

    if (bus.wgt_wr_en) begin
      if (state[wb] == BANK_FULL) begin
        ovf_n = 1'b1;
      end else if (wr_addr_ext < CNT_W'(DEPTH)) begin
        wr_ok       = 1'b1;
        state_n[wb] = BANK_FILLING;
        if (wr_addr_ext >= hi) hi_wr = wr_addr_ext + CNT_W'(1);
      end
    end
    hi_n = hi_wr;

    if (bus.wr_commit) begin
      if (state[wb] == BANK_FULL) begin
        ovf_n = 1'b1;
      end else if (state_n[wb] == BANK_FILLING) begin
        state_n[wb] = BANK_FULL;
        count_n[wb] = hi_wr;
        wb_n        = ~wb;
        hi_n        = '0;
      end
    end

    if (bus.rd_release && (state[rb] == BANK_FULL)) begin
      state_n[rb] = BANK_EMPTY;
      count_n[rb] = '0;
      rb_n        = ~rb;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    wgt_bank_ram #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
    ) u_ram (
      .clock (clock),
      .rst_n (rst_n),
      .we    (wr_ok && (wb == 1'(g))),
      .waddr (bus.wgt_wr_addr),
      .wdata ({bus.valid_num, bus.weights_in}),
      .re    (rd_ok && (rb == 1'(g))),
      .raddr (bus.rd_addr),
      .rdata (q[g])
    );
  end

  // Each bank's output register holds when not read, so muxing by the last-read bank holds rd_data.
  assign bus.rd_data     = q[sel][DATA_W-1:0];
  assign bus.rd_num      = q[sel][ENT_W-1:DATA_W];
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_count    = (state[rb] == BANK_FULL) ? count[rb] : '0;
  assign bus.buf_empty   = (state[0] != BANK_FULL) && (state[1] != BANK_FULL);
  assign bus.buf_full    = (state[0] == BANK_FULL) && (state[1] == BANK_FULL);
  assign bus.wr_overflow = ovf;

endmodule

// File: tb/tb_wgt_pingpong_buffer.sv
// Bench for wgt_pingpong_buffer: directed vector table plus randomized traffic vs. a queue-based model.
module tb_wgt_pingpong_buffer;
  import wgt_buf_pkg::*;

  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned NW    = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  wgt_pingpong_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_W(NW)) bus ();

  wgt_pingpong_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_W(NW)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            rst;
    bit            we;
    int unsigned   wa;
    logic [DW-1:0] wd;
    logic [NW-1:0] wn;
    bit            cm;
    bit            re;
    int unsigned   ra;
    bit            rl;
    bit            chk;
    bit            ev;
    logic [DW-1:0] ed;
    logic [NW-1:0] en;
    int unsigned   ec;
    bit            eempty;
    bit            efull;
    bit            eovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: physical bank = parity of commit/release counts, committed banks in a FIFO.
  logic [DW-1:0] md [2][DEPTH];
  logic [NW-1:0] mn [2][DEPTH];
  bit            mk [2][DEPTH];
  int unsigned   cq [$];
  int unsigned   commits = 0, releases = 0, fill_hi = 0;
  bit            fill_active = 0, m_ovf = 0;
  bit            e_valid = 0, e_known = 1;
  logic [DW-1:0] e_data = '0;
  logic [NW-1:0] e_num = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t v);
    int unsigned wbm, rbm, qsz;
    if (v.rst) begin
      cq.delete();
      commits = 0; releases = 0; fill_hi = 0; fill_active = 0; m_ovf = 0;
      e_valid = 0; e_known = 1; e_data = '0; e_num = '0;
      return;
    end
    wbm = commits % 2;
    rbm = releases % 2;
    qsz = cq.size();
    e_valid = 0;
    if (v.re && qsz > 0 && v.ra < cq[0]) begin
      e_valid = 1;
      e_data  = md[rbm][v.ra];
      e_num   = mn[rbm][v.ra];
      e_known = mk[rbm][v.ra];
    end
    if (v.we) begin
      if (qsz == 2) m_ovf = 1;
      else if (v.wa < DEPTH) begin
        md[wbm][v.wa] = v.wd;
        mn[wbm][v.wa] = v.wn;
        mk[wbm][v.wa] = 1;
        fill_active = 1;
        if (v.wa + 1 > fill_hi) fill_hi = v.wa + 1;
      end
    end
    if (v.cm) begin
      if (qsz == 2) m_ovf = 1;
      else if (fill_active) begin
        cq.push_back(fill_hi);
        commits++;
        fill_active = 0;
        fill_hi = 0;
      end
    end
    if (v.rl && qsz > 0) begin
      void'(cq.pop_front());
      releases++;
    end
  endtask

  task automatic step(input vec_t v);
    int unsigned mcount;
    rst_n           = ~v.rst;
    bus.wgt_wr_en   = v.we;
    bus.wgt_wr_addr = 7'(v.wa);
    bus.weights_in  = v.wd;
    bus.valid_num   = v.wn;
    bus.wr_commit   = v.cm;
    bus.rd_en       = v.re;
    bus.rd_addr     = 7'(v.ra);
    bus.rd_release  = v.rl;
    @(posedge clock);
    model_step(v);
    #1;
    mcount = (cq.size() > 0) ? cq[0] : 0;
    check("rd_valid", DW'(bus.rd_valid), DW'(e_valid));
    if (e_known) begin
      check("rd_data", bus.rd_data, e_data);
      check("rd_num", DW'(bus.rd_num), DW'(e_num));
    end
    check("rd_count", DW'(bus.rd_count), DW'(mcount));
    check("buf_empty", DW'(bus.buf_empty), DW'(cq.size() == 0));
    check("buf_full", DW'(bus.buf_full), DW'(cq.size() == 2));
    check("wr_overflow", DW'(bus.wr_overflow), DW'(m_ovf));
    if (v.chk) begin
      check("tbl_rd_valid", DW'(bus.rd_valid), DW'(v.ev));
      if (v.ev) begin
        check("tbl_rd_data", bus.rd_data, v.ed);
        check("tbl_rd_num", DW'(bus.rd_num), DW'(v.en));
      end
      check("tbl_rd_count", DW'(bus.rd_count), DW'(v.ec));
      check("tbl_buf_empty", DW'(bus.buf_empty), DW'(v.eempty));
      check("tbl_buf_full", DW'(bus.buf_full), DW'(v.efull));
      check("tbl_wr_overflow", DW'(bus.wr_overflow), DW'(v.eovf));
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.rst = 0; v.we = 0; v.wa = 0; v.wd = '0; v.wn = '0;
    v.cm = 0; v.re = 0; v.ra = 0; v.rl = 0;
    v.chk = 0; v.ev = 0; v.ed = '0; v.en = '0; v.ec = 0;
    v.eempty = 0; v.efull = 0; v.eovf = 0;
    return v;
  endfunction

  function automatic vec_t wr(input int unsigned a, input int unsigned d, input int unsigned n);
    vec_t v = blank();
    v.we = 1; v.wa = a; v.wd = DW'(d); v.wn = NW'(n);
    return v;
  endfunction

  function automatic vec_t op(input bit cm, input bit re, input int unsigned ra, input bit rl);
    vec_t v = blank();
    v.cm = cm; v.re = re; v.ra = ra; v.rl = rl;
    return v;
  endfunction

  function automatic vec_t rst_row();
    vec_t v = blank();
    v.rst = 1;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input bit ev, input int unsigned ed, input int unsigned en,
                              input int unsigned ec, input bit em, input bit fu, input bit ov);
    vec_t v = vi;
    v.chk = 1; v.ev = ev; v.ed = DW'(ed); v.en = NW'(en); v.ec = ec;
    v.eempty = em; v.efull = fu; v.eovf = ov;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [$];
    vec_t v;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) tbl.push_back(i == 4 ? ex(rst_row(), 0, 0, 0, 0, 1, 0, 0) : rst_row());
    tbl.push_back(blank());
    // Single fill/drain
    for (int unsigned a = 0; a < 27; a++) tbl.push_back(wr(a, a + 1, 3));
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 27, 0, 0, 0));
    tbl.push_back(ex(op(0, 1, 5, 0), 1, 6, 3, 27, 0, 0, 0));
    tbl.push_back(ex(op(0, 0, 0, 1), 0, 0, 0, 0, 1, 0, 0));
    // Ping-pong to full, overflow, release
    for (int unsigned a = 0; a < 9; a++) tbl.push_back(wr(a, 100 + a, 2));
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 9, 0, 0, 0));
    for (int unsigned a = 0; a < 9; a++) tbl.push_back(wr(a, 200 + a, 5));
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 9, 0, 1, 0));
    tbl.push_back(ex(wr(0, 999, 1), 0, 0, 0, 9, 0, 1, 1));
    tbl.push_back(ex(op(0, 0, 0, 1), 0, 0, 0, 9, 0, 0, 1));
    tbl.push_back(ex(op(0, 1, 8, 0), 1, 208, 5, 9, 0, 0, 1));
    tbl.push_back(ex(op(0, 1, 0, 0), 1, 200, 5, 9, 0, 0, 1));
    tbl.push_back(ex(op(0, 1, 9, 0), 0, 0, 0, 9, 0, 0, 1));
    // Commit + release (+ read of the old bank) in one cycle
    for (int unsigned a = 0; a < 4; a++) tbl.push_back(wr(a, 300 + a, 7));
    tbl.push_back(ex(op(1, 1, 2, 1), 1, 202, 5, 4, 0, 0, 1));
    tbl.push_back(ex(op(0, 1, 3, 0), 1, 303, 7, 4, 0, 0, 1));
    // Empty-bank commit and stray release
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 4, 0, 0, 1));
    tbl.push_back(ex(op(0, 0, 0, 1), 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(ex(op(0, 0, 0, 1), 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 0, 1, 0, 1));
    // Write and commit in the same cycle
    tbl.push_back(wr(0, 400, 1));
    v = wr(5, 405, 1);
    v.cm = 1;
    tbl.push_back(ex(v, 0, 0, 0, 6, 0, 0, 1));
    tbl.push_back(ex(op(0, 1, 5, 0), 1, 405, 1, 6, 0, 0, 1));
    // Mid-operation reset
    for (int unsigned a = 0; a < 3; a++) tbl.push_back(wr(a, 500 + a, 6));
    tbl.push_back(ex(rst_row(), 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(blank());
    for (int unsigned a = 0; a < 3; a++) tbl.push_back(wr(a, 600 + a, 9));
    tbl.push_back(ex(op(1, 0, 0, 0), 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(ex(op(0, 1, 2, 0), 1, 602, 9, 3, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = blank();
      v.rst = ($urandom_range(0, 399) == 0);
      v.we  = ($urandom_range(0, 99) < 50);
      v.wa  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
      v.wd  = {$urandom, $urandom, $urandom, $urandom};
      v.wn  = NW'($urandom);
      v.cm  = ($urandom_range(0, 99) < 8);
      v.re  = ($urandom_range(0, 99) < 50);
      v.ra  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
      v.rl  = ($urandom_range(0, 99) < 6);
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
